// File: rtl/alu_decode_stage_pkg.sv
// Shared core definitions for the ALU decode stage: ALU opcode enum, RV opcode
// constants and the decoded control bundle passed from decoder to pipeline register.
package alu_decode_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        alu_op_e    op;
        logic       imm_sel;
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [4:0] rd_addr;
        logic       rd_we;
    } dec_ctrl_t;

    // funct3 -> ALU op for the base (funct7 = 0000000) encodings
    function automatic alu_op_e base_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode_stage_decoder.sv
// Purely combinational OP / OP-IMM decoder (module alu_op_decoder); flags every
// other opcode/funct combination as illegal.
module alu_op_decoder
    import alu_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic            o_legal,
    output dec_ctrl_t       o_ctrl,
    output logic [XLEN-1:0] o_imm
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        o_legal         = 1'b0;
        o_ctrl.op       = ALU_ADD;
        o_ctrl.imm_sel  = 1'b0;
        o_ctrl.rs1_addr = i_instr[19:15];
        o_ctrl.rs2_addr = i_instr[24:20];
        o_ctrl.rd_addr  = i_instr[11:7];
        o_ctrl.rd_we    = |i_instr[11:7];
        o_imm           = '0;
        case (w_opcode)
            OPC_OP: begin
                if (w_funct7 == F7_BASE) begin
                    o_legal   = 1'b1;
                    o_ctrl.op = base_op(w_funct3);
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
                    o_legal   = 1'b1;
                    o_ctrl.op = ALU_SUB;
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
                    o_legal   = 1'b1;
                    o_ctrl.op = ALU_SRA;
                end
            end
            OPC_OP_IMM: begin
                o_ctrl.imm_sel  = 1'b1;
                o_ctrl.rs2_addr = 5'd0;
                case (w_funct3)
                    3'b001: begin
                        o_legal   = (w_funct7 == F7_BASE);
                        o_ctrl.op = ALU_SLL;
                        o_imm     = {{(XLEN-5){1'b0}}, i_instr[24:20]};
                    end
                    3'b101: begin
                        o_legal   = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
                        o_ctrl.op = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        o_imm     = {{(XLEN-5){1'b0}}, i_instr[24:20]};
                    end
                    default: begin
                        o_legal   = 1'b1;
                        o_ctrl.op = base_op(w_funct3);
                        o_imm     = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_decode_stage.sv
// ALU decode stage: fetch handshake, one output register, illegal counter.
// Define ALU_DECODE_SKID_EN to add a one-entry skid buffer and register o_if_ready.
module alu_decode_stage
    import alu_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic [31:0]     i_if_instr,
    input  logic            i_flush,
    output logic            o_ex_valid,
    input  logic            i_ex_ready,
    output logic [3:0]      o_ex_op,
    output logic            o_ex_imm_sel,
    output logic [XLEN-1:0] o_ex_imm,
    output logic [4:0]      o_ex_rs1_addr,
    output logic [4:0]      o_ex_rs2_addr,
    output logic [4:0]      o_ex_rd_addr,
    output logic            o_ex_rd_we,
    output logic            o_illegal,
    output logic [7:0]      o_illegal_cnt
);

    logic            w_legal;
    dec_ctrl_t       w_ctrl;
    logic [XLEN-1:0] w_imm;
    logic            w_accept;
    logic            w_load;
    logic            w_out_free;

    logic            r_ex_valid;
    dec_ctrl_t       r_ex_ctrl;
    logic [XLEN-1:0] r_ex_imm;
    logic            r_illegal;
    logic [7:0]      r_illegal_cnt;

    alu_op_decoder #(.XLEN(XLEN)) u_dec (
        .i_instr (i_if_instr),
        .o_legal (w_legal),
        .o_ctrl  (w_ctrl),
        .o_imm   (w_imm)
    );

    assign w_accept   = i_if_valid && o_if_ready && !i_flush;
    assign w_load     = w_accept && w_legal;
    assign w_out_free = !r_ex_valid || i_ex_ready;

`ifdef ALU_DECODE_SKID_EN
    logic            r_skid_valid;
    dec_ctrl_t       r_skid_ctrl;
    logic [XLEN-1:0] r_skid_imm;

    // Ready depends only on skid occupancy (and flush), never on i_ex_ready.
    assign o_if_ready = !r_skid_valid && !i_flush;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex_valid   <= 1'b0;
            r_ex_ctrl    <= '0;
            r_ex_imm     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_imm   <= '0;
        end else if (i_flush) begin
            r_ex_valid   <= 1'b0;
            r_ex_ctrl    <= '0;
            r_ex_imm     <= '0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_ex_valid   <= 1'b1;
                r_ex_ctrl    <= r_skid_ctrl;
                r_ex_imm     <= r_skid_imm;
                r_skid_valid <= 1'b0;
            end else if (w_load) begin
                r_ex_valid <= 1'b1;
                r_ex_ctrl  <= w_ctrl;
                r_ex_imm   <= w_imm;
            end else begin
                r_ex_valid <= 1'b0;
            end
        end else if (w_load) begin
            r_skid_valid <= 1'b1;
            r_skid_ctrl  <= w_ctrl;
            r_skid_imm   <= w_imm;
        end
    end
`else
    assign o_if_ready = w_out_free && !i_flush;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
            r_ex_imm   <= '0;
        end else if (i_flush) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
            r_ex_imm   <= '0;
        end else if (w_out_free) begin
            r_ex_valid <= w_load;
            if (w_load) begin
                r_ex_ctrl <= w_ctrl;
                r_ex_imm  <= w_imm;
            end
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_illegal     <= 1'b0;
            r_illegal_cnt <= '0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (w_accept && !w_legal && r_illegal_cnt != 8'hFF) begin
                r_illegal_cnt <= r_illegal_cnt + 8'd1;
            end
        end
    end

    assign o_ex_valid    = r_ex_valid;
    assign o_ex_op       = r_ex_ctrl.op;
    assign o_ex_imm_sel  = r_ex_ctrl.imm_sel;
    assign o_ex_imm      = r_ex_imm;
    assign o_ex_rs1_addr = r_ex_ctrl.rs1_addr;
    assign o_ex_rs2_addr = r_ex_ctrl.rs2_addr;
    assign o_ex_rd_addr  = r_ex_ctrl.rd_addr;
    assign o_ex_rd_we    = r_ex_ctrl.rd_we;
    assign o_illegal     = r_illegal;
    assign o_illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Randomized + directed bench for alu_decode_stage against a queue-based
// reference model (works with or without ALU_DECODE_SKID_EN).
module tb_alu_decode_stage;

    localparam int XLEN = 32;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic            i_if_valid;
    logic            o_if_ready;
    logic [31:0]     i_if_instr;
    logic            i_flush;
    logic            o_ex_valid;
    logic            i_ex_ready;
    logic [3:0]      o_ex_op;
    logic            o_ex_imm_sel;
    logic [XLEN-1:0] o_ex_imm;
    logic [4:0]      o_ex_rs1_addr;
    logic [4:0]      o_ex_rs2_addr;
    logic [4:0]      o_ex_rd_addr;
    logic            o_ex_rd_we;
    logic            o_illegal;
    logic [7:0]      o_illegal_cnt;

    alu_decode_stage #(.XLEN(XLEN)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_if_valid    (i_if_valid),
        .o_if_ready    (o_if_ready),
        .i_if_instr    (i_if_instr),
        .i_flush       (i_flush),
        .o_ex_valid    (o_ex_valid),
        .i_ex_ready    (i_ex_ready),
        .o_ex_op       (o_ex_op),
        .o_ex_imm_sel  (o_ex_imm_sel),
        .o_ex_imm      (o_ex_imm),
        .o_ex_rs1_addr (o_ex_rs1_addr),
        .o_ex_rs2_addr (o_ex_rs2_addr),
        .o_ex_rd_addr  (o_ex_rd_addr),
        .o_ex_rd_we    (o_ex_rd_we),
        .o_illegal     (o_illegal),
        .o_illegal_cnt (o_illegal_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        legal;
        logic [3:0]  op;
        logic        imm_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    logic m_illegal = 1'b0;
    int   m_cnt     = 0;
    int   base_op_tbl [8] = '{0, 7, 2, 3, 4, 8, 5, 6};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference decode written directly from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t e;
        logic [6:0] opc = ins[6:0];
        logic [2:0] f3  = ins[14:12];
        logic [6:0] f7  = ins[31:25];
        e.legal = 1'b0; e.op = 4'd0; e.imm_sel = 1'b0; e.imm = 32'd0;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.rd_we = (ins[11:7] != 5'd0);
        if (opc == 7'h33) begin
            if (f7 == 7'h00) begin
                e.legal = 1'b1; e.op = 4'(base_op_tbl[f3]);
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                e.legal = 1'b1; e.op = 4'd1;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                e.legal = 1'b1; e.op = 4'd9;
            end
        end else if (opc == 7'h13) begin
            e.imm_sel = 1'b1; e.rs2 = 5'd0;
            if (f3 == 3'd1) begin
                e.legal = (f7 == 7'h00); e.op = 4'd7; e.imm = 32'(ins[24:20]);
            end else if (f3 == 3'd5) begin
                e.legal = (f7 == 7'h00) || (f7 == 7'h20);
                e.op = (f7 == 7'h20) ? 4'd9 : 4'd8; e.imm = 32'(ins[24:20]);
            end else begin
                e.legal = 1'b1; e.op = 4'(base_op_tbl[f3]);
                e.imm = 32'($signed(ins[31:20]));
            end
        end
        return e;
    endfunction

    function automatic logic model_ready(input logic rdy, input logic fl);
`ifdef ALU_DECODE_SKID_EN
        return !fl && (q.size() < 2);
`else
        return !fl && (q.size() == 0 || rdy);
`endif
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        int sel = $urandom_range(0, 9);
        logic [6:0] f7;
        case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        if (sel <= 3)      r = {f7, r[24:7], 7'h33};
        else if (sel <= 7) r = {(r[14:12] == 3'd1 || r[14:12] == 3'd5) ? f7 : r[31:25], r[24:7], 7'h13};
        return r;
    endfunction

    // Drive one cycle at negedge, compare DUT against model, then advance the model.
    task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
        logic m_ready, m_acc;
        exp_t d;
        @(negedge i_clk);
        i_if_valid = v; i_if_instr = ins; i_ex_ready = rdy; i_flush = fl;
        #1;
        m_ready = model_ready(rdy, fl);
        check("if_ready", 32'(o_if_ready), 32'(m_ready));
        check("ex_valid", 32'(o_ex_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("ex_op",      32'(o_ex_op),       32'(q[0].op));
            check("ex_imm_sel", 32'(o_ex_imm_sel),  32'(q[0].imm_sel));
            check("ex_imm",     o_ex_imm,           q[0].imm);
            check("ex_rs1",     32'(o_ex_rs1_addr), 32'(q[0].rs1));
            check("ex_rs2",     32'(o_ex_rs2_addr), 32'(q[0].rs2));
            check("ex_rd",      32'(o_ex_rd_addr),  32'(q[0].rd));
            check("ex_rd_we",   32'(o_ex_rd_we),    32'(q[0].rd_we));
        end
        check("illegal",     32'(o_illegal),     32'(m_illegal));
        check("illegal_cnt", 32'(o_illegal_cnt), 32'(m_cnt));
        m_acc     = v && m_ready && !fl;
        d         = ref_decode(ins);
        m_illegal = m_acc && !d.legal;
        if (m_illegal && m_cnt < 255) m_cnt++;
        if (fl) q.delete();
        else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (m_acc && d.legal) q.push_back(d);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(o_ex_valid), 32'd0);
        check({tag, "_op"},    32'(o_ex_op), 32'd0);
        check({tag, "_imm"},   o_ex_imm, 32'd0);
        check({tag, "_regs"},  32'({o_ex_imm_sel, o_ex_rs1_addr, o_ex_rs2_addr, o_ex_rd_addr, o_ex_rd_we}), 32'd0);
        check({tag, "_ill"},   32'(o_illegal), 32'd0);
        check({tag, "_cnt"},   32'(o_illegal_cnt), 32'd0);
    endtask

    int cnt_before;

    initial begin
        i_rst_n = 1'b0; i_if_valid = 1'b0; i_if_instr = '0; i_ex_ready = 1'b1; i_flush = 1'b0;
        repeat (3) @(negedge i_clk);
        #1 check_all_zero("reset");
        #1 i_rst_n = 1'b1;

        // ADD x3,x1,x2
        step(1'b1, 32'h002081B3, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("add_valid", 32'(o_ex_valid), 32'd1);
        check("add_op", 32'(o_ex_op), 32'd0);
        check("add_fields", 32'({o_ex_imm_sel, o_ex_rs1_addr, o_ex_rs2_addr, o_ex_rd_addr, o_ex_rd_we}),
              32'({1'b0, 5'd1, 5'd2, 5'd3, 1'b1}));

        // ADDI x5,x0,-1
        step(1'b1, 32'hFFF00293, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("addi_imm", o_ex_imm, 32'hFFFFFFFF);
        check("addi_fields", 32'({o_ex_op, o_ex_imm_sel, o_ex_rd_addr, o_ex_rd_we}),
              32'({4'd0, 1'b1, 5'd5, 1'b1}));

        // SRAI x1,x1,4 then illegal funct7 variant
        step(1'b1, 32'h4040D093, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("srai_op", 32'(o_ex_op), 32'd9);
        check("srai_imm", o_ex_imm, 32'h4);
        check("srai_rs2", 32'(o_ex_rs2_addr), 32'd0);
        cnt_before = int'(o_illegal_cnt);
        step(1'b1, 32'h8040D093, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("bad_srai_pulse", 32'(o_illegal), 32'd1);
        check("bad_srai_cnt", 32'(o_illegal_cnt), 32'(cnt_before + 1));
        check("bad_srai_valid", 32'(o_ex_valid), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("pulse_one_cycle", 32'(o_illegal), 32'd0);

        // Stall for 3 cycles while two instructions are offered, then drain.
        step(1'b1, 32'h002081B3, 1'b1, 1'b0);
        step(1'b1, 32'h40208233, 1'b0, 1'b0);
        step(1'b1, 32'h40208233, 1'b0, 1'b0);
        step(1'b1, 32'h40208233, 1'b0, 1'b0);
`ifdef ALU_DECODE_SKID_EN
        check("skid_ready_low", 32'(o_if_ready), 32'd0);
`else
        check("noskid_ready_low", 32'(o_if_ready), 32'd0);
`endif
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // 300 all-zero words: all illegal, counter saturates.
        for (int i = 0; i < 300; i++) step(1'b1, 32'h0, 1'($urandom_range(0, 1)), 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("cnt_saturated", 32'(o_illegal_cnt), 32'd255);

        // Flush during stall.
        step(1'b1, 32'h002081B3, 1'b0, 1'b0);
        step(1'b1, 32'h00510113, 1'b0, 1'b0);
        step(1'b1, 32'h00510113, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("flush_valid", 32'(o_ex_valid), 32'd0);

        // Reset mid-stall.
        step(1'b1, 32'h002081B3, 1'b0, 1'b0);
        step(1'b1, 32'hFFF00293, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge i_clk);
        i_if_valid = 1'b0; i_flush = 1'b0;
        #2 i_rst_n = 1'b0;
        #1 check_all_zero("midrst");
        q.delete(); m_illegal = 1'b0; m_cnt = 0;
        @(negedge i_clk);
        #2 i_rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 9) < 7), rand_instr(),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/immediate width.
REQ-002 SHALL have i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have i_if_valid  input  1 / o_if_ready  output  1 / i_if_instr  input  32: fetch-side instruction handshake.
REQ-005 SHALL have i_flush  input  1  discards all held instructions.
REQ-006 SHALL have o_ex_valid  output  1 / i_ex_ready  input  1: ALU-side handshake.
REQ-007 SHALL have o_ex_op  output  4 (ALU opcode), o_ex_imm_sel  output  1, o_ex_imm  output  XLEN.
REQ-008 SHALL have o_ex_rs1_addr, o_ex_rs2_addr, o_ex_rd_addr  output  5 each; o_ex_rd_we  output  1.
REQ-009 SHALL have o_illegal  output  1 (one-cycle pulse) and o_illegal_cnt  output  8.

Function
REQ-010 SHALL accept an instruction on a cycle with i_if_valid && o_if_ready && !i_flush.
REQ-011 SHALL present decoded result with o_ex_valid=1 on the cycle after acceptance (latency 1).
REQ-012 SHALL hold all o_ex_* outputs stable while o_ex_valid && !i_ex_ready.
REQ-013 SHALL deassert o_ex_valid after i_ex_valid&&i_ex_ready unless a new instruction was accepted same cycle (back-to-back throughput 1/cycle).
REQ-014 SHALL decode OP (0110011): funct7 0000000 -> funct3 000 Add, 001 Sll, 010 Slt, 011 Sltu, 100 Xor, 101 Srl, 110 Or, 111 And; funct7 0100000 -> 000 Sub, 101 Sra; imm_sel=0, imm=0.
REQ-015 SHALL decode OP-IMM (0010011): 000 Add, 010 Slt, 011 Sltu, 100 Xor, 110 Or, 111 And with imm=sign-extend instr[31:20]; 001 Sll (instr[31:25]=0), 101 Srl (0000000)/Sra (0100000) with imm=zero-extend instr[24:20]; imm_sel=1, rs2_addr=0.
REQ-016 SHALL set rs1=instr[19:15], rs2=instr[24:20] (OP), rd=instr[11:7], rd_we=(rd!=0).
REQ-017 SHALL treat any other opcode/funct combination as illegal: consumed, o_ex_valid not asserted for it, o_illegal=1 the following cycle only.
REQ-018 SHALL increment o_illegal_cnt per illegal, saturating at 255.
REQ-019 SHALL, on i_flush, force o_ex_valid=0 (and skid empty) next edge and hold o_if_ready=0 that cycle; flush wins over simultaneous accept.

Reset
REQ-020 SHALL on !i_rst_n asynchronously clear o_ex_valid, o_illegal, o_illegal_cnt, skid state, and all o_ex_* data to 0.
REQ-021 SHALL drop any in-flight or stalled instruction on reset mid-operation; o_if_ready=1 from first cycle after reset release.

Configuration
REQ-022 SHALL honour macro ALU_DECODE_SKID_EN.
REQ-023 Without macro: o_if_ready = !o_ex_valid || i_ex_ready (combinational from i_ex_ready).
REQ-024 With macro: one-entry skid register; o_if_ready = !skid_valid (registered, no path from i_ex_ready); instruction accepted while output stalled goes to skid, moves to output on next drain; order preserved.

Structure
REQ-025 SHALL take ALU opcode enum (Add=0, Sub=1, Slt=2, Sltu=3, Xor=4, Or=5, And=6, Sll=7, Srl=8, Sra=9) and RV opcode constants from shared core package.
REQ-026 SHALL isolate pure combinational decode in sub-module alu_op_decoder; handshake/skid/counter in top.

Verification
REQ-027 0x002081B3 (ADD x3,x1,x2) -> next cycle valid, op=0, imm_sel=0, rs1=1, rs2=2, rd=3, rd_we=1.
REQ-028 0xFFF00293 (ADDI x5,x0,-1) -> op=0, imm_sel=1, imm=0xFFFFFFFF, rd=5, rd_we=1.
REQ-029 0x4040D093 (SRAI x1,x1,4) -> op=9, imm=0x00000004, rs2=0; 0x8040D093 -> illegal pulse, cnt+1.
REQ-030 i_ex_ready=0 for 3 cycles, two instructions offered -> outputs held; without macro second waits; with macro second in skid, o_if_ready=0, both delivered in order.
REQ-031 300 consecutive 0x00000000 -> o_ex_valid never 1, o_illegal_cnt=255 held.
REQ-032 i_flush during stall, then reset mid-stall -> o_ex_valid=0 next edge/immediately, all outputs 0.
